// File: rtl/ifid_stage_reg.sv
// IF/ID pipeline register for the WISC pipeline: captures fetch, pre-splits decode
// fields, and sequences call bubbles and return waits through a small FSM.
module ifid_stage_reg #(
    parameter int          PC_W         = 16,
    parameter logic [15:0] NOP_INSTR    = 16'hF000,
    parameter int          CALL_BUBBLES = 1,
    parameter int          RET_TIMEOUT  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     instr_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic            valid_in,
    input  logic            data_hazard,
    input  logic            pc_hazard,
    input  logic            call,
    input  logic            ret_control,
    input  logic            ret_pc,
    output logic [15:0]     instr_out,
    output logic            valid_out,
    output logic [PC_W-1:0] pc_out,
    output logic [2:0]      branch_cond,
    output logic [3:0]      reg_rd,
    output logic [3:0]      reg_rs,
    output logic [3:0]      reg_rt,
    output logic [3:0]      arith_imm,
    output logic [7:0]      load_save_imm,
    output logic [11:0]     call_target,
    output logic            fetch_stall,
    output logic            ret_timeout_err,
    output logic [1:0]      state_dbg        // 0=RUN, 1=CALL_DRAIN, 2=RET_WAIT
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        CALL_DRAIN = 2'd1,
        RET_WAIT   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_LOAD   = 2'd2
    } action_t;

    localparam logic [3:0] CNT_INIT = 4'(CALL_BUBBLES - 1);
    localparam logic [8:0] RET_TO   = 9'(RET_TIMEOUT);

    state_t     state, state_nxt;
    action_t    action;
    logic [3:0] cnt;
    logic [7:0] wcnt;
    logic [8:0] wcnt_inc;

    assign state_dbg = state;
    assign wcnt_inc  = {1'b0, wcnt} + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (pc_hazard) begin
                    state_nxt = RUN;
                end else if (call) begin
                    state_nxt = (CALL_BUBBLES == 1) ? RUN : CALL_DRAIN;
                end else if (ret_control) begin
                    state_nxt = RET_WAIT;
                end
            end
            CALL_DRAIN: begin
                if (cnt == 4'd1) begin
                    state_nxt = RUN;
                end
            end
            RET_WAIT: begin
                if (ret_pc) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Only RUN can hold or load; the other states always emit bubbles.
    always_comb begin
        action      = ACT_BUBBLE;
        fetch_stall = (state != RUN) | call | ret_control | (data_hazard & ~pc_hazard);
        if (state == RUN) begin
            if (pc_hazard || call || ret_control) begin
                action = ACT_BUBBLE;
            end else if (data_hazard) begin
                action = ACT_HOLD;
            end else if (!valid_in) begin
                action = ACT_BUBBLE;
            end else begin
                action = ACT_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= 4'd0;
            wcnt            <= 8'd0;
            ret_timeout_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!pc_hazard && call) begin
                        cnt <= CNT_INIT;
                    end else if (!pc_hazard && ret_control) begin
                        wcnt <= 8'd0;
                    end
                end
                CALL_DRAIN: begin
                    cnt <= cnt - 4'd1;
                end
                RET_WAIT: begin
                    if (!ret_pc) begin
                        if (wcnt != 8'hFF) begin
                            wcnt <= wcnt + 8'd1;
                        end
                        if (wcnt_inc >= RET_TO) begin
                            ret_timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    cnt <= 4'd0;
                end
            endcase
        end
    end

    // Decode fields and PC only move on a load so ID still sees the last real fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_out     <= NOP_INSTR;
            valid_out     <= 1'b0;
            pc_out        <= '0;
            branch_cond   <= 3'd0;
            reg_rd        <= 4'd0;
            reg_rs        <= 4'd0;
            reg_rt        <= 4'd0;
            arith_imm     <= 4'd0;
            load_save_imm <= 8'd0;
            call_target   <= 12'd0;
        end else begin
            case (action)
                ACT_LOAD: begin
                    instr_out     <= instr_in;
                    valid_out     <= 1'b1;
                    pc_out        <= pc_in;
                    branch_cond   <= instr_in[10:8];
                    reg_rd        <= instr_in[11:8];
                    reg_rs        <= instr_in[7:4];
                    reg_rt        <= instr_in[3:0];
                    arith_imm     <= instr_in[3:0];
                    load_save_imm <= instr_in[7:0];
                    call_target   <= instr_in[11:0];
                end
                ACT_BUBBLE: begin
                    instr_out <= NOP_INSTR;
                    valid_out <= 1'b0;
                end
                default: begin
                    instr_out <= instr_out;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifid_stage_reg.sv
// Scoreboard bench for ifid_stage_reg: a behavioural model predicts each cycle's
// outputs, a monitor compares them against the DUT on the falling edge.
module tb_ifid_stage_reg;

    localparam int          CB  = 3;
    localparam int          RT  = 2;
    localparam logic [15:0] NOP = 16'hF000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr_in = 16'h0;
    logic [15:0] pc_in = 16'h0;
    logic        valid_in = 1'b0;
    logic        data_hazard = 1'b0;
    logic        pc_hazard = 1'b0;
    logic        call = 1'b0;
    logic        ret_control = 1'b0;
    logic        ret_pc = 1'b0;
    logic [15:0] instr_out;
    logic        valid_out;
    logic [15:0] pc_out;
    logic [2:0]  branch_cond;
    logic [3:0]  reg_rd;
    logic [3:0]  reg_rs;
    logic [3:0]  reg_rt;
    logic [3:0]  arith_imm;
    logic [7:0]  load_save_imm;
    logic [11:0] call_target;
    logic        fetch_stall;
    logic        ret_timeout_err;
    logic [1:0]  state_dbg;

    ifid_stage_reg #(
        .PC_W(16), .NOP_INSTR(NOP), .CALL_BUBBLES(CB), .RET_TIMEOUT(RT)
    ) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in),
        .data_hazard(data_hazard), .pc_hazard(pc_hazard), .call(call),
        .ret_control(ret_control), .ret_pc(ret_pc), .instr_out(instr_out),
        .valid_out(valid_out), .pc_out(pc_out), .branch_cond(branch_cond),
        .reg_rd(reg_rd), .reg_rs(reg_rs), .reg_rt(reg_rt), .arith_imm(arith_imm),
        .load_save_imm(load_save_imm), .call_target(call_target),
        .fetch_stall(fetch_stall), .ret_timeout_err(ret_timeout_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic [15:0] instr;
        logic        valid;
        logic [15:0] pc;
        logic        err;
        logic [15:0] last;
        logic        idle;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Model: what ID sees plus the outstanding work left from calls and returns.
    logic [15:0] m_instr, m_pc, m_last;
    logic        m_valid, m_err, m_waiting;
    int          m_call_left, m_wait_n;

    task automatic model_reset();
        m_instr = NOP; m_valid = 1'b0; m_pc = 16'h0; m_last = 16'h0; m_err = 1'b0;
        m_waiting = 1'b0; m_call_left = 0; m_wait_n = 0;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic vin, input logic [15:0] ins,
                        input logic [15:0] pc, input logic dh, input logic ph,
                        input logic cl, input logic rc, input logic rp);
        exp_t e;
        logic busy;
        @(posedge clk);
        #1;
        rst = r; valid_in = vin; instr_in = ins; pc_in = pc; data_hazard = dh;
        pc_hazard = ph; call = cl; ret_control = rc; ret_pc = rp;
        if (r) model_reset();
        busy = (m_call_left > 0) || m_waiting;
        e.stall = busy || cl || rc || (dh && !ph);
        e.instr = m_instr; e.valid = m_valid; e.pc = m_pc; e.err = m_err;
        e.last = m_last; e.idle = !busy;
        exp_q.push_back(e);
        if (!r) begin
            if (m_call_left > 0) begin
                m_instr = NOP; m_valid = 1'b0; m_call_left--;
            end else if (m_waiting) begin
                m_instr = NOP; m_valid = 1'b0;
                if (rp) m_waiting = 1'b0;
                else begin
                    if (m_wait_n < 255) m_wait_n++;
                    if (m_wait_n >= RT) m_err = 1'b1;
                end
            end else if (ph) begin
                m_instr = NOP; m_valid = 1'b0;
            end else if (cl) begin
                m_instr = NOP; m_valid = 1'b0; m_call_left = CB - 1;
            end else if (rc) begin
                m_instr = NOP; m_valid = 1'b0; m_waiting = 1'b1; m_wait_n = 0;
            end else if (dh) begin
                // hold: nothing moves
            end else if (!vin) begin
                m_instr = NOP; m_valid = 1'b0;
            end else begin
                m_instr = ins; m_valid = 1'b1; m_pc = pc; m_last = ins;
            end
        end
    endtask

    task automatic load(input logic [15:0] ins, input logic [15:0] pc);
        step(0, 1, ins, pc, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("fetch_stall", 16'(fetch_stall), 16'(mon_e.stall));
            check("instr_out", instr_out, mon_e.instr);
            check("valid_out", 16'(valid_out), 16'(mon_e.valid));
            check("pc_out", pc_out, mon_e.pc);
            check("ret_timeout_err", 16'(ret_timeout_err), 16'(mon_e.err));
            check("branch_cond", 16'(branch_cond), 16'(mon_e.last[10:8]));
            check("reg_rd", 16'(reg_rd), 16'(mon_e.last[11:8]));
            check("reg_rs", 16'(reg_rs), 16'(mon_e.last[7:4]));
            check("reg_rt", 16'(reg_rt), 16'(mon_e.last[3:0]));
            check("arith_imm", 16'(arith_imm), 16'(mon_e.last[3:0]));
            check("load_save_imm", 16'(load_save_imm), 16'(mon_e.last[7:0]));
            check("call_target", 16'(call_target), 16'(mon_e.last[11:0]));
            check("state_idle", 16'(state_dbg == 2'd0), 16'(mon_e.idle));
        end
    end

    initial begin
        model_reset();
        step(1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        step(1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        // stream
        load(16'h1234, 16'd0);
        load(16'h2567, 16'd1);
        load(16'h3ABC, 16'd2);
        load(16'h4111, 16'd3);
        // data hazard hold, then hazard + flush
        step(0, 1, 16'h5AAA, 16'd4, 1, 0, 0, 0, 0);
        step(0, 1, 16'h5AAA, 16'd4, 1, 0, 0, 0, 0);
        step(0, 1, 16'h5AAA, 16'd4, 1, 1, 0, 0, 0);
        load(16'h6123, 16'd5);
        step(0, 0, 16'h7777, 16'd6, 0, 0, 0, 0, 0);
        // call with ret_control ignored mid-drain
        step(0, 1, 16'h8001, 16'd7, 0, 0, 1, 0, 0);
        step(0, 1, 16'h8002, 16'd8, 1, 0, 0, 1, 0);
        step(0, 1, 16'h8003, 16'd9, 0, 1, 1, 0, 1);
        load(16'h9004, 16'd10);
        load(16'h9005, 16'd11);
        // return with ret_pc four cycles later
        step(0, 1, 16'hA001, 16'd12, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 16'hA002, 16'd13, 1, 0, 1, 0, 0);
        step(0, 1, 16'hA003, 16'd14, 0, 0, 0, 0, 1);
        load(16'hB004, 16'd15);
        // ret_pc ignored in RUN; timeout stays sticky after ret_pc
        step(0, 1, 16'hB005, 16'd16, 0, 0, 0, 0, 1);
        step(0, 1, 16'hC001, 16'd17, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 16'd0, 0, 0, 0, 0, 0);
        step(0, 0, 16'h0, 16'd0, 0, 0, 0, 0, 1);
        load(16'hC002, 16'd18);
        // async reset in the middle of a return wait
        step(0, 1, 16'hD001, 16'd19, 0, 0, 0, 1, 0);
        step(0, 1, 16'hD002, 16'd20, 0, 0, 0, 0, 0);
        step(1, 0, 16'h0, 16'd0, 0, 0, 0, 0, 0);
        step(0, 0, 16'h0, 16'd0, 0, 0, 0, 0, 0);
        load(16'hD003, 16'd21);
        // simultaneous call and return: call wins
        step(0, 1, 16'hE001, 16'd22, 0, 0, 1, 1, 0);
        step(0, 1, 16'hE002, 16'd23, 0, 0, 0, 0, 0);
        step(0, 1, 16'hE003, 16'd24, 0, 0, 0, 0, 0);
        load(16'hE004, 16'd25);
        load(16'hE005, 16'd26);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
